ttt_game_ctrl: RTL and testbench

Tic-tac-toe game controller sitting directly upstream of the screen/line-drawing stage. It accepts player move requests, validates them against the board, alternates X/O, and detects win/draw. It issues one draw command per accepted move (grid first, then marks) to the screen stage over a req/done handshake. The board state it holds is the authoritative game state.

---
 rtl/ttt_pkg.sv | 53 +++++
 rtl/ttt_win_detect.sv | 38 +++
 rtl/ttt_game_ctrl.sv | 122 ++++++++++++
 tb/tb_ttt_game_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe controller: cell/state encodings,
// winner codes, the eight winning lines and a board cell accessor.
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned CELL_W    = 4;
    localparam int unsigned BOARD_W   = 2 * NUM_CELLS;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned LINE_W    = 4;
    localparam int unsigned COUNT_W   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        S_GRID  = 3'd0,
        S_IDLE  = 3'd1,
        S_DRAW  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_X    = 2'b01;
    localparam logic [1:0] WINNER_O    = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    localparam logic [LINE_W-1:0] NO_LINE = 4'hF;

    // Rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
    localparam logic [CELL_W-1:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Cell contents at index idx; indices above 8 read as EMPTY.
    function automatic cell_t cell_at(input logic [BOARD_W-1:0] b, input logic [CELL_W-1:0] idx);
        cell_at = EMPTY;
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (idx == CELL_W'(i)) cell_at = cell_t'(b[2*i +: 2]);
        end
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line check: does `mark` own a full line on `board`, and which one.
// TTT_WIN_LINE_EN enables the line-index encoder; otherwise line is fixed at 4'hF.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  cell_t              mark,
    output logic               hit,
    output logic [LINE_W-1:0]  line
);

    logic [NUM_LINES-1:0] w_owned;

    always_comb begin
        w_owned = '0;
        for (int l = 0; l < int'(NUM_LINES); l++) begin
            w_owned[l] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (cell_at(board, WIN_LINES[l][k]) != mark) w_owned[l] = 1'b0;
            end
        end
    end

    assign hit = |w_owned;

`ifdef TTT_WIN_LINE_EN
    // Descending scan so the lowest completed line index wins.
    always_comb begin
        line = NO_LINE;
        for (int l = int'(NUM_LINES) - 1; l >= 0; l--) begin
            if (w_owned[l]) line = LINE_W'(l);
        end
    end
`else
    assign line = NO_LINE;
`endif

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: validates moves, alternates X/O, detects win/draw and
// sequences grid/mark draw requests to the screen stage. Option: TTT_WIN_LINE_EN.
module ttt_game_ctrl
    import ttt_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [CELL_W-1:0]  move_cell,
    input  logic               grid_done,
    input  logic               draw_done,
    output logic               grid_req,
    output logic               draw_req,
    output logic [CELL_W-1:0]  draw_cell,
    output logic               draw_mark,
    output logic [BOARD_W-1:0] board,
    output logic               player,
    output logic               move_reject,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [LINE_W-1:0]  win_line
);

    state_t               r_state;
    logic [BOARD_W-1:0]   r_board;
    logic                 r_player;
    logic [COUNT_W-1:0]   r_move_count;
    logic [1:0]           r_winner;
    logic [LINE_W-1:0]    r_win_line;
    logic                 r_move_reject;
    logic [CELL_W-1:0]    r_draw_cell;
    logic                 r_draw_mark;

    cell_t                w_mark;
    logic                 w_legal;
    logic                 w_hit;
    logic [LINE_W-1:0]    w_line;

    assign w_mark  = r_player ? O : X;
    assign w_legal = (move_cell <= CELL_W'(NUM_CELLS - 1)) && (cell_at(r_board, move_cell) == EMPTY);

    // Evaluated against the registered board with the last mover's mark.
    ttt_win_detect u_win_detect (
        .board (r_board),
        .mark  (w_mark),
        .hit   (w_hit),
        .line  (w_line)
    );

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            r_state       <= S_GRID;
            r_board       <= '0;
            r_player      <= 1'b0;
            r_move_count  <= '0;
            r_winner      <= WINNER_NONE;
            r_win_line    <= NO_LINE;
            r_move_reject <= 1'b0;
            if (reset) begin
                r_draw_cell <= '0;
                r_draw_mark <= 1'b0;
            end
        end else begin
            r_move_reject <= 1'b0;
            case (r_state)
                S_GRID: begin
                    if (grid_done) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (move_valid) begin
                        if (w_legal) begin
                            for (int i = 0; i < int'(NUM_CELLS); i++) begin
                                if (move_cell == CELL_W'(i)) r_board[2*i +: 2] <= w_mark;
                            end
                            r_draw_cell  <= move_cell;
                            r_draw_mark  <= r_player;
                            r_move_count <= r_move_count + COUNT_W'(1);
                            r_state      <= S_DRAW;
                        end else begin
                            r_move_reject <= 1'b1;
                        end
                    end
                end
                S_DRAW: begin
                    if (draw_done) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_winner   <= r_player ? WINNER_O : WINNER_X;
                        r_win_line <= w_line;
                        r_state    <= S_OVER;
                    end else if (r_move_count == COUNT_W'(NUM_CELLS)) begin
                        r_winner <= WINNER_DRAW;
                        r_state  <= S_OVER;
                    end else begin
                        r_player <= ~r_player;
                        r_state  <= S_IDLE;
                    end
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_GRID;
                end
            endcase
        end
    end

    assign grid_req    = (r_state == S_GRID);
    assign draw_req    = (r_state == S_DRAW);
    assign game_over   = (r_state == S_OVER);
    assign draw_cell   = r_draw_cell;
    assign draw_mark   = r_draw_mark;
    assign board       = r_board;
    assign player      = r_player;
    assign move_reject = r_move_reject;
    assign winner      = r_winner;
    assign win_line    = r_win_line;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl; inputs driven and outputs sampled
// on the falling clock edge.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [3:0]  move_cell = 4'd0;
    logic        grid_done = 1'b0;
    logic        draw_done = 1'b0;
    logic        grid_req;
    logic        draw_req;
    logic [3:0]  draw_cell;
    logic        draw_mark;
    logic [17:0] board;
    logic        player;
    logic        move_reject;
    logic        game_over;
    logic [1:0]  winner;
    logic [3:0]  win_line;

    int checks = 0;
    int errors = 0;

`ifdef TTT_WIN_LINE_EN
    localparam logic [3:0] EXP_LINE_ROW0 = 4'd0;
    localparam logic [3:0] EXP_LINE_DIAG = 4'd7;
`else
    localparam logic [3:0] EXP_LINE_ROW0 = 4'hF;
    localparam logic [3:0] EXP_LINE_DIAG = 4'hF;
`endif

    always #10 clk = ~clk;

    ttt_game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_cell   (move_cell),
        .grid_done   (grid_done),
        .draw_done   (draw_done),
        .grid_req    (grid_req),
        .draw_req    (draw_req),
        .draw_cell   (draw_cell),
        .draw_mark   (draw_mark),
        .board       (board),
        .player      (player),
        .move_reject (move_reject),
        .game_over   (game_over),
        .winner      (winner),
        .win_line    (win_line)
    );

    // Stimulus primitives; each starts and ends at a falling edge.
    task automatic pulse_new_game();
        new_game = 1'b1; @(negedge clk); new_game = 1'b0;
    endtask

    task automatic pulse_grid_done();
        grid_done = 1'b1; @(negedge clk); grid_done = 1'b0;
    endtask

    task automatic pulse_move(input logic [3:0] c);
        move_valid = 1'b1; move_cell = c; @(negedge clk); move_valid = 1'b0;
    endtask

    task automatic play(input logic [3:0] c);
        pulse_move(c);
        draw_done = 1'b1; @(negedge clk); draw_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_game();
        pulse_new_game();
        pulse_grid_done();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (board !== 18'h0) begin errors++; $display("FAIL reset_board got %h exp %h", board, 18'h0); end
        checks++; if (player !== 1'b0) begin errors++; $display("FAIL reset_player got %b exp 0", player); end
        checks++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b exp 00", winner); end
        checks++; if (win_line !== 4'hF) begin errors++; $display("FAIL reset_win_line got %h exp f", win_line); end
        checks++; if ({move_reject, draw_cell, draw_mark, game_over} !== 7'b0) begin
            errors++; $display("FAIL reset_misc got rej=%b cell=%h mark=%b over=%b exp all 0", move_reject, draw_cell, draw_mark, game_over);
        end
        checks++; if ({grid_req, draw_req} !== 2'b10) begin errors++; $display("FAIL reset_reqs got grid=%b draw=%b exp 1 0", grid_req, draw_req); end
        pulse_grid_done();
        checks++; if (grid_req !== 1'b0) begin errors++; $display("FAIL grid_to_idle got grid_req=%b exp 0", grid_req); end
    endtask

    task automatic test_win_row();
        pulse_move(4'd0);
        checks++; if (board !== 18'h00001) begin errors++; $display("FAIL accept_board got %h exp %h", board, 18'h00001); end
        checks++; if ({draw_req, draw_cell, draw_mark} !== 6'b1_0000_0) begin
            errors++; $display("FAIL accept_draw got req=%b cell=%h mark=%b exp 1 0 0", draw_req, draw_cell, draw_mark);
        end
        draw_done = 1'b1; @(negedge clk); draw_done = 1'b0;
        checks++; if (player !== 1'b0) begin errors++; $display("FAIL player_in_check got %b exp 0", player); end
        @(negedge clk);
        checks++; if (player !== 1'b1) begin errors++; $display("FAIL player_toggle got %b exp 1", player); end
        play(4'd3); play(4'd1); play(4'd4); play(4'd2);
        checks++; if (winner !== 2'b01) begin errors++; $display("FAIL row_winner got %b exp 01", winner); end
        checks++; if (win_line !== EXP_LINE_ROW0) begin errors++; $display("FAIL row_line got %h exp %h", win_line, EXP_LINE_ROW0); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL row_over got %b exp 1", game_over); end
        checks++; if (board !== 18'h00295) begin errors++; $display("FAIL row_board got %h exp %h", board, 18'h00295); end
        pulse_move(4'd5);
        checks++; if ({move_reject, board} !== {1'b0, 18'h00295}) begin
            errors++; $display("FAIL over_ignore got rej=%b board=%h exp 0 %h", move_reject, board, 18'h00295);
        end
    endtask

    task automatic test_occupied();
        pulse_new_game();
        checks++; if ({grid_req, game_over, board, player, winner, win_line} !== {2'b10, 18'h0, 1'b0, 2'b00, 4'hF}) begin
            errors++; $display("FAIL new_game_clear got grid=%b over=%b board=%h pl=%b win=%b line=%h", grid_req, game_over, board, player, winner, win_line);
        end
        pulse_grid_done();
        play(4'd4);
        pulse_move(4'd4);
        checks++; if ({move_reject, draw_req} !== 2'b10) begin errors++; $display("FAIL occ_reject got rej=%b draw=%b exp 1 0", move_reject, draw_req); end
        @(negedge clk);
        checks++; if (move_reject !== 1'b0) begin errors++; $display("FAIL occ_reject_width got %b exp 0", move_reject); end
        checks++; if ({player, board} !== {1'b1, 18'h00100}) begin errors++; $display("FAIL occ_state got pl=%b board=%h exp 1 %h", player, board, 18'h00100); end
    endtask

    task automatic test_range();
        pulse_move(4'd9);
        checks++; if ({move_reject, draw_req} !== 2'b10) begin errors++; $display("FAIL range9 got rej=%b draw=%b exp 1 0", move_reject, draw_req); end
        @(negedge clk);
        pulse_move(4'd15);
        checks++; if ({move_reject, draw_req} !== 2'b10) begin errors++; $display("FAIL range15 got rej=%b draw=%b exp 1 0", move_reject, draw_req); end
        @(negedge clk);
        checks++; if ({move_reject, draw_req, board} !== {2'b00, 18'h00100}) begin
            errors++; $display("FAIL range_after got rej=%b draw=%b board=%h", move_reject, draw_req, board);
        end
    endtask

    task automatic test_draw_game();
        start_game();
        play(4'd0); play(4'd1); play(4'd2); play(4'd4); play(4'd3);
        play(4'd5); play(4'd7); play(4'd6); play(4'd8);
        checks++; if ({winner, win_line, game_over} !== {2'b11, 4'hF, 1'b1}) begin
            errors++; $display("FAIL draw_result got win=%b line=%h over=%b exp 11 f 1", winner, win_line, game_over);
        end
        checks++; if (board !== 18'h16A59) begin errors++; $display("FAIL draw_board got %h exp %h", board, 18'h16A59); end
    endtask

    task automatic test_o_diag();
        start_game();
        play(4'd0); play(4'd2); play(4'd1); play(4'd4); play(4'd5); play(4'd6);
        checks++; if ({winner, win_line, player} !== {2'b10, EXP_LINE_DIAG, 1'b1}) begin
            errors++; $display("FAIL diag_result got win=%b line=%h pl=%b exp 10 %h 1", winner, win_line, player, EXP_LINE_DIAG);
        end
        checks++; if (board !== 18'h02625) begin errors++; $display("FAIL diag_board got %h exp %h", board, 18'h02625); end
    endtask

    task automatic test_ninth_move_win();
        start_game();
        play(4'd1); play(4'd4); play(4'd2); play(4'd5); play(4'd3);
        play(4'd7); play(4'd6); play(4'd8); play(4'd0);
        checks++; if ({winner, win_line, game_over} !== {2'b01, EXP_LINE_ROW0, 1'b1}) begin
            errors++; $display("FAIL ninth_win got win=%b line=%h over=%b exp 01 %h 1", winner, win_line, game_over, EXP_LINE_ROW0);
        end
        checks++; if (board !== 18'h29A55) begin errors++; $display("FAIL ninth_board got %h exp %h", board, 18'h29A55); end
    endtask

    task automatic test_restart_mid_draw();
        start_game();
        play(4'd0);
        pulse_move(4'd4);
        checks++; if (draw_req !== 1'b1) begin errors++; $display("FAIL restart_pre got draw_req=%b exp 1", draw_req); end
        pulse_new_game();
        checks++; if ({draw_req, grid_req, board, player} !== {2'b01, 18'h0, 1'b0}) begin
            errors++; $display("FAIL restart_post got draw=%b grid=%b board=%h pl=%b exp 0 1 0 0", draw_req, grid_req, board, player);
        end
    endtask

    task automatic test_ignored_inputs();
        pulse_grid_done();
        pulse_grid_done();
        checks++; if (grid_req !== 1'b0) begin errors++; $display("FAIL grid_done_idle got grid_req=%b exp 0", grid_req); end
        draw_done = 1'b1; @(negedge clk); draw_done = 1'b0;
        checks++; if ({draw_req, player} !== 2'b00) begin errors++; $display("FAIL draw_done_idle got draw=%b pl=%b exp 0 0", draw_req, player); end
        pulse_move(4'd2);
        pulse_move(4'd5);
        checks++; if ({move_reject, draw_req, draw_cell, board} !== {2'b01, 4'd2, 18'h00010}) begin
            errors++; $display("FAIL mv_in_draw got rej=%b draw=%b cell=%h board=%h exp 0 1 2 %h", move_reject, draw_req, draw_cell, board, 18'h00010);
        end
        draw_done = 1'b1; @(negedge clk); draw_done = 1'b0;
        @(negedge clk);
        checks++; if ({player, draw_req, board} !== {2'b10, 18'h00010}) begin
            errors++; $display("FAIL turn_after_ignore got pl=%b draw=%b board=%h exp 1 0 %h", player, draw_req, board, 18'h00010);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_win_row();
        test_occupied();
        test_range();
        test_draw_game();
        test_o_diag();
        test_ninth_move_win();
        test_restart_mid_draw();
        test_ignored_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
